// File: rtl/muldiv_unit_pkg.sv
// Shared M-extension funct3 codes, FSM state type and op-decoding helpers for muldiv_unit.
package muldiv_unit_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX,
        MD_DONE
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return f3[1];
    endfunction

    // DIV/REM are signed (funct3[0]=0); DIVU/REMU are unsigned.
    function automatic logic op_div_signed(input logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

    function automatic logic op_mul_a_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU);
    endfunction

    function automatic logic op_mul_b_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MULH);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider: load, then one quotient bit per step; finish_o marks the last step.
module muldiv_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            finish_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic [XLEN-1:0]  rem_d, quo_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    shifted, diff;

    // quot_o/rem_o are the post-step values, so the final bit is usable on the finishing step.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (diff[XLEN]) begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        quot_o   = quo_d;
        rem_o    = rem_d;
        finish_o = step_i && (cnt_q == CNT_W'(XLEN - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with busy/done handshake and kill.
// Optional `MULDIV_DIVREM_FUSE_EN reuses the last completed division's quotient/remainder.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam bit              MUL_FAST = (MUL_LAT == 1);
    localparam int unsigned     CNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam int unsigned     CNT_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  a_q, b_q, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, qneg_q, rneg_q;

    logic             accept, is_div, sdiv, a_neg, b_neg, b_zero, ovf, fhit, div_load;
    logic [XLEN-1:0]  a_abs, b_abs, spec_res, fres;
    logic [2:0]       m_op;
    logic [XLEN-1:0]  m_a, m_b, mul_res;
    logic [2*XLEN-1:0] mx, my, prod;
    logic             div_last;
    logic [XLEN-1:0]  dq, dr, q_fix, r_fix;

`ifdef MULDIV_DIVREM_FUSE_EN
    logic             fv_q, fs_q;
    logic [XLEN-1:0]  fa_q, fb_q, fq_q, fr_q;
`endif

    always_comb begin
        accept   = start && !busy_q && !kill;
        is_div   = op_is_div(op);
        sdiv     = op_div_signed(op);
        a_neg    = sdiv && a[XLEN-1];
        b_neg    = sdiv && b[XLEN-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        b_zero   = (b == '0);
        ovf      = sdiv && (a == XMIN) && (b == '1);
        if (b_zero) spec_res = op_is_rem(op) ? a : '1;
        else        spec_res = op_is_rem(op) ? '0 : a;
`ifdef MULDIV_DIVREM_FUSE_EN
        fhit = fv_q && (fa_q == a) && (fb_q == b) && (fs_q == sdiv);
        fres = op_is_rem(op) ? fr_q : fq_q;
`else
        fhit = 1'b0;
        fres = '0;
`endif
        div_load = accept && is_div && !b_zero && !ovf && !fhit;
    end

    // Full-width product mod 2^(2*XLEN) after sign/zero extension covers all four multiply ops.
    always_comb begin
        m_op    = MUL_FAST ? op : op_q;
        m_a     = MUL_FAST ? a  : a_q;
        m_b     = MUL_FAST ? b  : b_q;
        mx      = {{XLEN{op_mul_a_signed(m_op) & m_a[XLEN-1]}}, m_a};
        my      = {{XLEN{op_mul_b_signed(m_op) & m_b[XLEN-1]}}, m_b};
        prod    = mx * my;
        mul_res = (m_op == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    muldiv_divider #(.XLEN(XLEN)) u_divider (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (div_load),
        .step_i     (state_q == MD_DIV),
        .dividend_i (a_abs),
        .divisor_i  (b_abs),
        .finish_o   (div_last),
        .quot_o     (dq),
        .rem_o      (dr)
    );

    always_comb begin
        q_fix = qneg_q ? -dq : dq;
        r_fix = rneg_q ? -dr : dr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
`ifdef MULDIV_DIVREM_FUSE_EN
            fv_q     <= 1'b0;
            fs_q     <= 1'b0;
            fa_q     <= '0;
            fb_q     <= '0;
            fq_q     <= '0;
            fr_q     <= '0;
`endif
        end else if (kill) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIVREM_FUSE_EN
            fv_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_MUL: begin
                    if (cnt_q == CNT_W'(CNT_LAST)) begin
                        result_q <= mul_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= MD_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Sign fix is applied to the final step's output, so FIX is the division's done cycle.
                MD_DIV: begin
                    if (div_last) begin
                        result_q <= op_q[1] ? r_fix : q_fix;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= MD_FIX;
`ifdef MULDIV_DIVREM_FUSE_EN
                        fv_q     <= 1'b1;
                        fs_q     <= op_div_signed(op_q);
                        fa_q     <= a_q;
                        fb_q     <= b_q;
                        fq_q     <= q_fix;
                        fr_q     <= r_fix;
`endif
                    end
                end
                MD_FIX, MD_DONE: state_q <= MD_IDLE;
                default:         state_q <= MD_IDLE;
            endcase

            if (accept) begin
                op_q   <= op;
                a_q    <= a;
                b_q    <= b;
                cnt_q  <= '0;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                if (!is_div) begin
                    if (MUL_FAST) begin
                        result_q <= mul_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= MD_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= MD_MUL;
                    end
                end else if (b_zero || ovf) begin
                    result_q <= spec_res;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= MD_DONE;
                end else if (fhit) begin
                    result_q <= fres;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= MD_DONE;
                end else begin
                    busy_q  <= 1'b1;
                    state_q <= MD_DIV;
                end
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
